// File: rtl/led_pkg.sv
// Shared constants for the LED pattern generator.
//   MODE_*    : encodings of the 2-bit mode input
//   DIR_*     : bounce direction flag values (left = towards the MSB)
package led_pkg;

  localparam logic [1:0] MODE_BLINK  = 2'b00;
  localparam logic [1:0] MODE_CHASE  = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_COUNT  = 2'b11;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/led_pattern_gen_tick_divider.sv
// tick_divider: prescaler that produces the pattern step strobe.
//   CLOCK_50 : system clock
//   RESET_N  : asynchronous active-low reset
//   run      : count enable (enable=1 and not paused)
//   clear    : synchronous clear of the counter, wins over run
//   speed    : registered speed select; period = PERIOD_CYCLES >> speed
//   step     : high during the cycle in which the counter sits on its terminal value while running
module tick_divider
  import led_pkg::*;
#(
  parameter int unsigned PERIOD_CYCLES = 25_000_000
)
(
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       run,
  input  logic       clear,
  input  logic [1:0] speed,
  output logic       step
);

  localparam int unsigned CNT_W = $clog2(PERIOD_CYCLES);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] term_s;
  logic             at_term_s;

  // terminal count for the selected speed and the resulting step strobe
  always_comb begin
    term_s    = CNT_W'((PERIOD_CYCLES >> speed) - 32'd1);
    at_term_s = (cnt_r == term_s);
    step      = run & at_term_s;
  end

  // prescaler counter: clear beats run, wraps to zero on the terminal count
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (run) begin
      if (at_term_s) begin
        cnt_r <= {CNT_W{1'b0}};
      end else begin
        cnt_r <= cnt_r + CNT_W'(1'b1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: LED pattern engine for the LEDG bank.
//   CLOCK_50 : system clock
//   RESET_N  : asynchronous active-low reset
//   enable   : 1 = run, 0 = LEDs dark and engine parked at its initial state
//   pause    : freeze prescaler and pattern (mode/speed changes still land)
//   mode     : 00 blink, 01 chase, 10 bounce, 11 binary count
//   speed    : step period = PERIOD_CYCLES >> speed
//   LEDG     : registered LED drive
//   tick     : registered one-cycle pulse alongside each pattern step
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int unsigned PERIOD_CYCLES = 25_000_000,
  parameter int unsigned N_LEDS        = 8
)
(
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic              enable,
  input  logic              pause,
  input  logic [1:0]        mode,
  input  logic [1:0]        speed,
  output logic [N_LEDS-1:0] LEDG,
  output logic              tick
);

  // starting vector for a mode: chase and bounce start with a single lit LED
  function automatic logic [N_LEDS-1:0] init_pattern(input logic [1:0] m);
    logic [N_LEDS-1:0] p;
    case (m)
      MODE_CHASE,
      MODE_BOUNCE: p = {{(N_LEDS-1){1'b0}}, 1'b1};
      default:     p = {N_LEDS{1'b0}};
    endcase
    return p;
  endfunction

  logic [1:0]        mode_q_r,  mode_q_nxt_s;
  logic [1:0]        speed_q_r, speed_q_nxt_s;
  logic [N_LEDS-1:0] led_r,     led_nxt_s;
  logic              dir_r,     dir_nxt_s;
  logic              tick_r,    tick_nxt_s;
  // idle_r marks that the engine was disabled and must reload on the next enabled edge
  logic              idle_r,    idle_nxt_s;

  logic [N_LEDS-1:0] adv_led_s;
  logic              adv_dir_s;
  logic              mode_chg_s;
  logic              speed_chg_s;
  logic              run_s;
  logic              clear_s;
  logic              step_s;

  // change detection and prescaler control
  always_comb begin
    mode_chg_s  = (mode  != mode_q_r);
    speed_chg_s = (speed != speed_q_r);
    run_s       = enable & ~pause;
    clear_s     = ~enable | mode_chg_s | speed_chg_s | idle_r;
  end

  tick_divider #(
    .PERIOD_CYCLES (PERIOD_CYCLES)
  ) u_tick_divider (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .run      (run_s),
    .clear    (clear_s),
    .speed    (speed_q_r),
    .step     (step_s)
  );

  // one step of the active pattern, with the bounce direction it leaves behind
  always_comb begin
    adv_led_s = led_r;
    adv_dir_s = dir_r;
    case (mode_q_r)
      MODE_BLINK: adv_led_s = ~led_r;
      MODE_CHASE: adv_led_s = {led_r[N_LEDS-2:0], led_r[N_LEDS-1]};
      MODE_BOUNCE: begin
        // turn around as the lit bit lands on an end, so the end value shows once
        if (dir_r == DIR_LEFT) begin
          adv_led_s = led_r << 1'b1;
          adv_dir_s = led_r[N_LEDS-2] ? DIR_RIGHT : DIR_LEFT;
        end else begin
          adv_led_s = led_r >> 1'b1;
          adv_dir_s = led_r[1] ? DIR_LEFT : DIR_RIGHT;
        end
      end
      MODE_COUNT: adv_led_s = led_r + {{(N_LEDS-1){1'b0}}, 1'b1};
      default:    adv_led_s = led_r;
    endcase
  end

  // next-state selection: disable > mode change > speed change > reload > pause > step
  always_comb begin
    mode_q_nxt_s  = mode_q_r;
    speed_q_nxt_s = speed_q_r;
    led_nxt_s     = led_r;
    dir_nxt_s     = dir_r;
    tick_nxt_s    = 1'b0;
    idle_nxt_s    = idle_r;
    if (!enable) begin
      led_nxt_s  = {N_LEDS{1'b0}};
      dir_nxt_s  = DIR_LEFT;
      idle_nxt_s = 1'b1;
    end else if (mode_chg_s) begin
      mode_q_nxt_s = mode;
      led_nxt_s    = init_pattern(mode);
      dir_nxt_s    = DIR_LEFT;
      idle_nxt_s   = 1'b0;
    end else if (speed_chg_s) begin
      // a coincident step is dropped; LEDs keep their value
      speed_q_nxt_s = speed;
    end else if (idle_r) begin
      led_nxt_s  = init_pattern(mode_q_r);
      dir_nxt_s  = DIR_LEFT;
      idle_nxt_s = 1'b0;
    end else if (pause) begin
      led_nxt_s = led_r;
    end else if (step_s) begin
      led_nxt_s  = adv_led_s;
      dir_nxt_s  = adv_dir_s;
      tick_nxt_s = 1'b1;
    end else begin
      led_nxt_s = led_r;
    end
  end

  // engine and output registers
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      mode_q_r  <= MODE_BLINK;
      speed_q_r <= 2'b00;
      led_r     <= {N_LEDS{1'b0}};
      dir_r     <= DIR_LEFT;
      tick_r    <= 1'b0;
      idle_r    <= 1'b0;
    end else begin
      mode_q_r  <= mode_q_nxt_s;
      speed_q_r <= speed_q_nxt_s;
      led_r     <= led_nxt_s;
      dir_r     <= dir_nxt_s;
      tick_r    <= tick_nxt_s;
      idle_r    <= idle_nxt_s;
    end
  end

  assign LEDG = led_r;
  assign tick = tick_r;

endmodule
